// File: rtl/aes_pkg.sv
// Shared AES definitions: datapath widths and the S-box share controller state type.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_WORD_W  = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ST_RUN  = 3'd1,
    KW_RUN  = 3'd2,
    ST_DONE = 3'd3,
    KW_DONE = 3'd4
  } sbox_state_e;

  typedef enum logic {
    GNT_ST = 1'b0,
    GNT_KW = 1'b1
  } sbox_grant_e;

endpackage

// File: rtl/sbox_share_ctrl_if.sv
// Request/response bundle between the round/key-expansion clients and the shared S-box controller.
interface sbox_share_ctrl_if;
  import aes_pkg::*;

  logic                   st_req_valid;
  logic                   st_req_ready;
  logic [AES_BLOCK_W-1:0] st_req_data;
  logic                   st_rsp_valid;
  logic                   st_rsp_ready;
  logic [AES_BLOCK_W-1:0] st_rsp_data;

  logic                   kw_req_valid;
  logic                   kw_req_ready;
  logic [AES_WORD_W-1:0]  kw_req_data;
  logic                   kw_rsp_valid;
  logic                   kw_rsp_ready;
  logic [AES_WORD_W-1:0]  kw_rsp_data;

  modport master (
    output st_req_valid, st_req_data, st_rsp_ready,
    output kw_req_valid, kw_req_data, kw_rsp_ready,
    input  st_req_ready, st_rsp_valid, st_rsp_data,
    input  kw_req_ready, kw_rsp_valid, kw_rsp_data
  );

  modport slave (
    input  st_req_valid, st_req_data, st_rsp_ready,
    input  kw_req_valid, kw_req_data, kw_rsp_ready,
    output st_req_ready, st_rsp_valid, st_rsp_data,
    output kw_req_ready, kw_rsp_valid, kw_rsp_data
  );

endinterface

// File: rtl/aes_sbox.sv
// AES forward S-box as a purely combinational table lookup.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Entry 0 occupies the most significant byte of the table.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX_TABLE[8*(255-int'(a)) +: 8];

endmodule

// File: rtl/sbox_bank.sv
// LANES parallel combinational S-boxes shared between state and key-word substitution.
module sbox_bank #(
  parameter int LANES = 4
) (
  input  logic [LANES*8-1:0] lane_in,
  output logic [LANES*8-1:0] lane_out
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    aes_sbox u_sbox (
      .a (lane_in[8*i +: 8]),
      .y (lane_out[8*i +: 8])
    );
  end

endmodule

// File: rtl/sbox_share_ctrl.sv
// Time-shares one S-box bank between 128-bit SubBytes and 32-bit SubWord requests.
// Define SBOX_RR_ARB_EN for round-robin arbitration; otherwise key-word requests win on contention.
module sbox_share_ctrl
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  sbox_share_ctrl_if.slave   bus,
  output logic               busy
);

  localparam int BEATS  = 16 / LANES;
  localparam int LANE_W = LANES * 8;

  sbox_state_e            state_q, state_d;
  logic [AES_BLOCK_W-1:0] buf_q, buf_d;
  logic [3:0]             beat_q, beat_d;
  logic [LANE_W-1:0]      lane_in, lane_out;
  logic                   grant_kw;
  logic                   idle_ok;
  logic                   st_acc, kw_acc;

  sbox_bank #(.LANES(LANES)) u_bank (
    .lane_in  (lane_in),
    .lane_out (lane_out)
  );

  // Ready is withheld during reset so nothing is accepted on a reset edge.
  assign idle_ok          = (state_q == IDLE) && !rst;
  assign bus.st_req_ready = idle_ok && bus.st_req_valid && !grant_kw;
  assign bus.kw_req_ready = idle_ok && bus.kw_req_valid && grant_kw;
  assign st_acc           = bus.st_req_valid && bus.st_req_ready;
  assign kw_acc           = bus.kw_req_valid && bus.kw_req_ready;

`ifdef SBOX_RR_ARB_EN
  sbox_grant_e last_q, last_d;

  always_comb begin
    if (bus.st_req_valid && bus.kw_req_valid) grant_kw = (last_q == GNT_ST);
    else                                      grant_kw = bus.kw_req_valid;
    last_d = last_q;
    if (st_acc)      last_d = GNT_ST;
    else if (kw_acc) last_d = GNT_KW;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= GNT_ST;
    else     last_q <= last_d;
  end
`else
  assign grant_kw = bus.kw_req_valid;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    beat_d  = beat_q;
    lane_in = '0;
    unique case (state_q)
      IDLE: begin
        if (kw_acc) begin
          buf_d   = {{(AES_BLOCK_W-AES_WORD_W){1'b0}}, bus.kw_req_data};
          beat_d  = '0;
          state_d = KW_RUN;
        end else if (st_acc) begin
          buf_d   = bus.st_req_data;
          beat_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        lane_in = buf_q[int'(beat_q)*LANE_W +: LANE_W];
        buf_d[int'(beat_q)*LANE_W +: LANE_W] = lane_out;
        beat_d  = beat_q + 4'd1;
        if (beat_q == 4'(BEATS-1)) state_d = ST_DONE;
      end
      KW_RUN: begin
        lane_in[AES_WORD_W-1:0] = buf_q[AES_WORD_W-1:0];
        buf_d[AES_WORD_W-1:0]   = lane_out[AES_WORD_W-1:0];
        state_d = KW_DONE;
      end
      ST_DONE: if (bus.st_rsp_ready) state_d = IDLE;
      KW_DONE: if (bus.kw_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the buffer is
  // cleared on reset because its contents drive the response data outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      beat_q  <= beat_d;
    end
  end

  assign bus.st_rsp_valid = (state_q == ST_DONE);
  assign bus.kw_rsp_valid = (state_q == KW_DONE);
  assign bus.st_rsp_data  = buf_q;
  assign bus.kw_rsp_data  = buf_q[AES_WORD_W-1:0];
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Self-checking bench for sbox_share_ctrl; the reference S-box is computed from GF(2^8) arithmetic.
module tb_sbox_share_ctrl;
  import aes_pkg::*;

  localparam int LANES = 4;
  localparam int BEATS = 16 / LANES;
`ifdef SBOX_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   errors = 0;
  int   checks = 0;
  bit   last_kw = 1'b0;

  sbox_share_ctrl_if bus ();

  sbox_share_ctrl #(.LANES(LANES)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    if (a == 8'h00) return 8'h00;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] b = ginv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_state(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_ref(d[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox_ref(d[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive_idle();
    bus.st_req_valid = 1'b0;
    bus.st_req_data  = '0;
    bus.st_rsp_ready = 1'b0;
    bus.kw_req_valid = 1'b0;
    bus.kw_req_data  = '0;
    bus.kw_rsp_ready = 1'b0;
  endtask

  // Presents one request, waits (bounded) for the handshake, then drops valid.
  task automatic send_req(input bit kw, input logic [127:0] d, output bit ok);
    int n = 0;
    @(negedge clk);
    if (kw) begin
      bus.kw_req_valid = 1'b1;
      bus.kw_req_data  = d[31:0];
    end else begin
      bus.st_req_valid = 1'b1;
      bus.st_req_data  = d;
    end
    #1;
    while (!(kw ? bus.kw_req_ready : bus.st_req_ready) && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = kw ? bus.kw_req_ready : bus.st_req_ready;
    if (ok) last_kw = kw;
    @(negedge clk);
    bus.st_req_valid = 1'b0;
    bus.kw_req_valid = 1'b0;
  endtask

  // Cycles from the handshake cycle (cycle 0) until rsp_valid is seen; 40 means timeout.
  task automatic wait_rsp(input bit kw, output int lat);
    lat = 1;
    #1;
    while (!(kw ? bus.kw_rsp_valid : bus.st_rsp_valid) && lat < 40) begin
      @(negedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish_rsp(input bit kw);
    if (kw) bus.kw_rsp_ready = 1'b1;
    else    bus.st_rsp_ready = 1'b1;
    @(negedge clk);
    bus.kw_rsp_ready = 1'b0;
    bus.st_rsp_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] flags;
    drive_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    flags = {bus.st_req_ready, bus.kw_req_ready, bus.st_rsp_valid, bus.kw_rsp_valid, busy};
    checks++;
    if (flags !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000", flags);
    end
    checks++;
    if (bus.st_rsp_data !== 128'h0 || bus.kw_rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got st=%h kw=%h want 0", bus.st_rsp_data, bus.kw_rsp_data);
    end
    @(negedge clk);
    rst = 1'b0;
    last_kw = 1'b0;
  endtask

  task automatic test_st_zero();
    bit ok;
    int lat;
    logic [127:0] exp63 = {16{8'h63}};
    send_req(1'b0, 128'h0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL st_zero_accept: got 0 want 1"); end
    wait_rsp(1'b0, lat);
    checks++;
    if (lat != BEATS + 1) begin
      errors++;
      $display("FAIL st_zero_latency: got %0d want %0d", lat, BEATS + 1);
    end
    checks++;
    if (bus.st_rsp_data !== exp63) begin
      errors++;
      $display("FAIL st_zero_data: got %h want %h", bus.st_rsp_data, exp63);
    end
    finish_rsp(1'b0);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL st_zero_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_kw_word();
    bit ok;
    int lat;
    send_req(1'b1, 128'h03020100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL kw_accept: got 0 want 1"); end
    wait_rsp(1'b1, lat);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL kw_latency: got %0d want 2", lat); end
    checks++;
    if (bus.kw_rsp_data !== 32'h7b777c63) begin
      errors++;
      $display("FAIL kw_data: got %h want 7b777c63", bus.kw_rsp_data);
    end
    finish_rsp(1'b1);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL kw_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_hold();
    bit ok;
    int lat;
    logic [127:0] d = {rand128()} & ~128'hff | 128'h53;
    logic [127:0] exp = ref_state(d);
    logic [3:0] flags;
    send_req(1'b0, d, ok);
    wait_rsp(1'b0, lat);
    checks++;
    if (!ok || lat != BEATS + 1) begin
      errors++;
      $display("FAIL hold_start: accept=%0d latency=%0d want 1/%0d", ok, lat, BEATS + 1);
    end
    bus.st_req_valid = 1'b1;
    bus.kw_req_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      flags = {bus.st_rsp_valid, busy, bus.st_req_ready, bus.kw_req_ready};
      checks++;
      if (flags !== 4'b1100) begin
        errors++;
        $display("FAIL hold_flags[%0d]: got %b want 1100", c, flags);
      end
      checks++;
      if (bus.st_rsp_data !== exp || bus.st_rsp_data[7:0] !== 8'hed) begin
        errors++;
        $display("FAIL hold_data[%0d]: got %h want %h", c, bus.st_rsp_data, exp);
      end
    end
    bus.st_rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.st_req_ready !== 1'b0 || bus.kw_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_handshake_ready: got st=%b kw=%b want 0/0", bus.st_req_ready, bus.kw_req_ready);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL hold_release: busy got %b want 0", busy); end
  endtask

  task automatic test_random();
    bit ok;
    int lat;
    bit kw;
    logic [127:0] d;
    for (int t = 0; t < 24; t++) begin
      kw = 1'($urandom_range(0, 1));
      d  = rand128();
      send_req(kw, d, ok);
      wait_rsp(kw, lat);
      checks++;
      if (!ok || lat != (kw ? 2 : BEATS + 1)) begin
        errors++;
        $display("FAIL rand_latency[%0d]: kw=%0d accept=%0d got %0d want %0d", t, kw, ok, lat, kw ? 2 : BEATS + 1);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++;
      if (kw ? (bus.kw_rsp_data !== ref_word(d[31:0])) : (bus.st_rsp_data !== ref_state(d))) begin
        errors++;
        $display("FAIL rand_data[%0d]: got %h / %h want %h / %h", t, bus.st_rsp_data, bus.kw_rsp_data,
                 ref_state(d), ref_word(d[31:0]));
      end
      finish_rsp(kw);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rand_idle[%0d]: busy got %b want 0", t, busy); end
    end
  endtask

  task automatic test_contention();
    int lat;
    bit exp_kw;
    logic [127:0] sd, kd;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_kw = 1'b0;
    for (int r = 0; r < 3; r++) begin
      exp_kw = RR ? !last_kw : 1'b1;
      sd = rand128();
      kd = rand128();
      @(negedge clk);
      bus.st_req_valid = 1'b1;
      bus.st_req_data  = sd;
      bus.kw_req_valid = 1'b1;
      bus.kw_req_data  = kd[31:0];
      #1;
      checks++;
      if ({bus.kw_req_ready, bus.st_req_ready} !== {exp_kw, !exp_kw}) begin
        errors++;
        $display("FAIL contention_grant[%0d]: got kw=%b st=%b want kw=%b st=%b", r,
                 bus.kw_req_ready, bus.st_req_ready, exp_kw, !exp_kw);
      end
      last_kw = exp_kw;
      @(negedge clk);
      bus.st_req_valid = 1'b0;
      bus.kw_req_valid = 1'b0;
      wait_rsp(exp_kw, lat);
      checks++;
      if (exp_kw ? (bus.kw_rsp_data !== ref_word(kd[31:0])) : (bus.st_rsp_data !== ref_state(sd))) begin
        errors++;
        $display("FAIL contention_data[%0d]: got %h / %h want %h / %h", r, bus.st_rsp_data,
                 bus.kw_rsp_data, ref_state(sd), ref_word(kd[31:0]));
      end
      finish_rsp(exp_kw);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int lat;
    logic [4:0] flags;
    send_req(1'b0, rand128(), ok);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_kw = 1'b0;
    #1;
    flags = {bus.st_req_ready, bus.kw_req_ready, bus.st_rsp_valid, bus.kw_rsp_valid, busy};
    checks++;
    if (!ok || flags !== 5'b0) begin
      errors++;
      $display("FAIL midreset_flags: accept=%0d got %b want 00000", ok, flags);
    end
    checks++;
    if (bus.st_rsp_data !== 128'h0 || bus.kw_rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL midreset_data: got st=%h kw=%h want 0", bus.st_rsp_data, bus.kw_rsp_data);
    end
    send_req(1'b1, 128'hc0ffee11, ok);
    wait_rsp(1'b1, lat);
    checks++;
    if (!ok || lat != 2 || bus.st_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_kw_timing: accept=%0d latency=%0d st_rsp_valid=%b want 1/2/0", ok, lat,
               bus.st_rsp_valid);
    end
    checks++;
    if (bus.kw_rsp_data !== ref_word(32'hc0ffee11)) begin
      errors++;
      $display("FAIL midreset_kw_data: got %h want %h", bus.kw_rsp_data, ref_word(32'hc0ffee11));
    end
    finish_rsp(1'b1);
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_st_zero();
    test_kw_word();
    test_hold();
    test_random();
    test_contention();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sbox_share_ctrl.md
SBOX_SHARE_CTRL -- requirements
Module: sbox_share_ctrl

Interface
REQ-001 SHALL have parameter LANES, default 4: number of shared S-box lanes; legal values 4, 8, 16; BEATS = 16/LANES.
REQ-002 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port st_req_valid, input, 1: round-state SubBytes request.
REQ-005 SHALL have port st_req_ready, output, 1: state request accepted when valid and ready are both high.
REQ-006 SHALL have port st_req_data, input, 128: state in; byte i = bits [8i+7:8i].
REQ-007 SHALL have port st_rsp_valid, output, 1: substituted state available.
REQ-008 SHALL have port st_rsp_ready, input, 1: state consumer accepts.
REQ-009 SHALL have port st_rsp_data, output, 128: substituted state.
REQ-010 SHALL have port kw_req_valid, input, 1: key-expansion SubWord request.
REQ-011 SHALL have port kw_req_ready, output, 1: word request accepted when valid and ready are both high.
REQ-012 SHALL have port kw_req_data, input, 32: word in, same byte order as the state.
REQ-013 SHALL have port kw_rsp_valid, output, 1: substituted word available.
REQ-014 SHALL have port kw_rsp_ready, input, 1: word consumer accepts.
REQ-015 SHALL have port kw_rsp_data, output, 32: substituted word.
REQ-016 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-017 SHALL use one FSM with states IDLE, ST_RUN, KW_RUN, ST_DONE and KW_DONE; one request is in service at a time.
REQ-018 SHALL assert req_ready only in IDLE, and only toward the arbitration winner; ready MAY depend combinationally on both valids.
REQ-019 SHALL go IDLE -> ST_RUN on an accepted state request: latch data into a 128-bit buffer and clear the beat counter.
REQ-020 SHALL, in ST_RUN, substitute buffer bytes k*LANES .. k*LANES+LANES-1 in beat k through the shared bank, write them back in place, then increment k.
REQ-021 SHALL go ST_RUN -> ST_DONE after beat BEATS-1, so st_rsp_valid rises BEATS+1 cycles after the accept edge (5 cycles for LANES=4).
REQ-022 SHALL go IDLE -> KW_RUN on an accepted word request, substitute the word in one beat on lanes 0-3 (other lanes idle), then go to KW_DONE; kw_rsp_valid rises 2 cycles after the accept edge.
REQ-023 SHALL, in a DONE state, hold rsp_valid high and rsp_data stable until rsp_ready is high, then return to IDLE on the next edge; no new accept occurs in the handshake cycle.
REQ-024 SHALL, when the default arbitration applies and both valids are high in IDLE, grant kw (fixed priority).
REQ-025 SHALL drive S-box lane inputs to 8'h00 when no beat is active.

Reset
REQ-026 SHALL, on rst high at any edge including mid-beat or in a DONE state, enter IDLE and drop the in-flight request without any response.
REQ-027 SHALL reset all outputs to 0: both ready, both rsp_valid, busy and all rsp_data bits; the buffer and beat counter SHALL also clear to 0.

Configuration
REQ-028 SHALL, when macro SBOX_RR_ARB_EN is defined, use round-robin arbitration: a last-grant flag (reset value = st) updates on each accept, and on contention the requester not granted last wins.
REQ-029 SHALL, when SBOX_RR_ARB_EN is undefined, use the fixed kw priority of REQ-024 with no last-grant flag.

Structure
REQ-030 SHALL take from shared package aes_pkg: AES_BLOCK_W=128, AES_WORD_W=32 and the FSM state enum type.
REQ-031 SHALL place the lanes in one sub-module, sbox_bank: LANES parallel instances of the team's combinational sbox, with no registers.

Verification
REQ-032 SHALL cover: LANES=4, st_req_data all 8'h00 -> st_rsp_data all 8'h63, with st_rsp_valid high exactly 5 cycles after the accept.
REQ-033 SHALL cover: kw_req_data 32'h03020100 -> kw_rsp_data 32'h7b777c63, with kw_rsp_valid high 2 cycles after the accept.
REQ-034 SHALL cover: both valids high in IDLE -> kw is granted first, in both builds; with SBOX_RR_ARB_EN, a second contention -> st is granted.
REQ-035 SHALL cover: st_rsp_ready held low for 10 cycles with st_req_data byte0 = 8'h53 -> st_rsp_data[7:0] stays 8'hed, busy stays high and both ready stay low.
REQ-036 SHALL cover: rst pulsed in beat 2 of ST_RUN -> next cycle all outputs are 0 and the state is IDLE; a fresh kw request then completes normally.
